// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer
//   Instruction fetch front end. Owns the fetch PC, issues in-order requests
//   to instruction memory, queues returned (pc, inst) pairs in a DEPTH-entry
//   FIFO and hands them to decode. A redirect flushes the queue and discards
//   every response that is still in flight.
//
// Parameters
//   DEPTH     FIFO entries; also the credit limit for in-flight plus queued
//             fetches. Must be a power of two, >= 2.
//   RESET_PC  fetch PC after reset.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   imem_req_*        request channel to memory (valid/ready, 64-bit address)
//   imem_resp_*       response channel from memory (valid only, in order)
//   out_*             head-of-queue entry toward decode (valid/ready)
//   redirect_*        flush and refetch from redirect_pc (bits [1:0] ignored)
//
// Configuration
//   IFU_BYPASS_EN  when defined, a response arriving into an empty queue is
//                  presented on out_* combinationally in the same cycle.
module ifu_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [63:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [CW:0]  credit_used;
  logic         req_fire;
  logic         resp_fire;
  logic         drop_resp;
  logic         keep_resp;
  logic         fifo_valid;
  logic         fifo_pop;
  logic         push;
  logic         bypass_take;
  logic [63:0]  redirect_target;
  logic         unused_pc_bits;

  // Every accepted request reserves a FIFO slot until decode consumes it,
  // so the queue can never overflow when responses come back.
  assign credit_used    = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_fire  = imem_resp_valid && (inflight != '0);
  assign drop_resp  = resp_fire && (discard != '0);
  assign keep_resp  = resp_fire && (discard == '0);
  assign fifo_valid = (count != '0);

  assign redirect_target = {redirect_pc[63:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc[1:0];

`ifdef IFU_BYPASS_EN
  // Empty queue and a kept response: show it to decode this same cycle.
  // If decode takes it, it never enters the FIFO.
  logic bypass_valid;
  assign bypass_valid = !rst && !fifo_valid && keep_resp;
  assign out_valid    = (!rst && fifo_valid) || bypass_valid;
  assign out_pc       = rst ? '0 : (fifo_valid ? pc_mem[rd_ptr]   : resp_pc);
  assign out_inst     = rst ? '0 : (fifo_valid ? inst_mem[rd_ptr] : imem_resp_inst);
  assign bypass_take  = bypass_valid && out_ready;
`else
  assign out_valid    = !rst && fifo_valid;
  assign out_pc       = rst ? '0 : pc_mem[rd_ptr];
  assign out_inst     = rst ? '0 : inst_mem[rd_ptr];
  assign bypass_take  = 1'b0;
`endif

  assign push     = keep_resp && !bypass_take;
  assign fifo_pop = fifo_valid && out_ready;

  // Control state. Reset beats redirect, redirect beats everything else.
  // On redirect the discard count becomes everything still outstanding
  // after this cycle, which also covers a redirect during an earlier discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      resp_pc  <= redirect_target;
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= inflight - CW'(resp_fire);
      discard  <= inflight - CW'(resp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
      inflight <= inflight + CW'(req_fire) - CW'(resp_fire);
      if (drop_resp) begin
        discard <= discard - CW'(1);
      end
      if (keep_resp) begin
        resp_pc <= resp_pc + 64'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(fifo_pop);
    end
  end

  // Queue storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= imem_resp_inst;
    end
  end

  resp_without_request: assert property (
    @(posedge clk) disable iff (rst) imem_resp_valid |-> (inflight != '0));

  discard_within_inflight: assert property (
    @(posedge clk) disable iff (rst) discard <= inflight);

endmodule
